// File: rtl/fetch_timing_generator_if.sv
// Bus between the fetch timing generator and its surroundings: memory data,
// decode feedback and ready come in; T-state, IR, sync, sequence flags and
// the PC increment enable go out.
interface fetch_timing_generator_if;
    logic       rdy;
    logic [7:0] db_in;
    logic       t_end;
    logic       pc_inc_req;
    logic       irq_pending;
    logic       sync;
    logic [2:0] t_state;
    logic [7:0] ir;
    logic       i_pc;
    logic       rst_seq;
    logic       irq_seq;

    modport master (
        output rdy, db_in, t_end, pc_inc_req, irq_pending,
        input  sync, t_state, ir, i_pc, rst_seq, irq_seq
    );

    modport slave (
        input  rdy, db_in, t_end, pc_inc_req, irq_pending,
        output sync, t_state, ir, i_pc, rst_seq, irq_seq
    );
endinterface

// File: rtl/fetch_timing_generator.sv
// Cycle timing and opcode-fetch sequencer upstream of the program counter.
// Tracks the T-state, latches the opcode into IR, predecodes single-byte
// opcodes and produces the PC increment enable. Reset and interrupts are
// handled by running an injected BRK with the fetched byte replaced by 00.
module fetch_timing_generator (
    input  logic                     phi_2,
    input  logic                     res_n,
    fetch_timing_generator_if.slave  bus
);

    typedef enum logic [2:0] {
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6,
        T7 = 3'd7
    } t_state_e;

    t_state_e   state;
    t_state_e   state_next;
    logic       sync_q;
    logic       sync_next;
    logic [7:0] ir_q;
    logic [7:0] ir_next;
    logic       rst_q;
    logic       rst_next;
    logic       irq_q;
    logic       irq_next;
    logic       single_byte;
    logic       i_pc;

    // State registers update on the falling edge, same as the PC registers.
    always_ff @(negedge phi_2 or negedge res_n) begin
        if (!res_n) begin
            state  <= T2;
            sync_q <= 1'b0;
            ir_q   <= 8'h00;
            rst_q  <= 1'b1;
            irq_q  <= 1'b0;
        end else begin
            state  <= state_next;
            sync_q <= sync_next;
            ir_q   <= ir_next;
            rst_q  <= rst_next;
            irq_q  <= irq_next;
        end
    end

    // Next-state: hold on stall, otherwise restart at T1 on t_end or count up to T7.
    always_comb begin
        state_next = state;
        sync_next  = sync_q;
        ir_next    = ir_q;
        rst_next   = rst_q;
        irq_next   = irq_q;
        if (bus.rdy) begin
            if (sync_q) begin
                ir_next = irq_q ? 8'h00 : bus.db_in;
            end
            if (bus.t_end && (state != T1)) begin
                state_next = T1;
                sync_next  = 1'b1;
                irq_next   = bus.irq_pending;
                rst_next   = 1'b0;
            end else begin
                sync_next = 1'b0;
                unique case (state)
                    T1:      state_next = T2;
                    T2:      state_next = T3;
                    T3:      state_next = T4;
                    T4:      state_next = T5;
                    T5:      state_next = T6;
                    T6:      state_next = T7;
                    default: state_next = T7;
                endcase
            end
        end
    end

    assign single_byte = (ir_q[3:0] == 4'h8) || (ir_q[3:0] == 4'hA);

    // PC increment enable: opcode and operand bytes advance the PC unless a forced BRK runs.
    always_comb begin
        i_pc = 1'b0;
        if (bus.rdy) begin
            unique case (state)
                T1:      i_pc = !irq_q;
                T2:      i_pc = !(single_byte || irq_q || rst_q);
                default: i_pc = bus.pc_inc_req && !irq_q && !rst_q;
            endcase
        end
    end

    assign bus.sync    = sync_q;
    assign bus.t_state = state;
    assign bus.ir      = ir_q;
    assign bus.i_pc    = i_pc;
    assign bus.rst_seq = rst_q;
    assign bus.irq_seq = irq_q;

endmodule

// File: tb/tb_fetch_timing_generator.sv
// Directed bench for fetch_timing_generator. A cycle-level model derives the
// expected outputs from the sequencing rules and is compared every cycle;
// literal expectations at key cycles pin the model itself.
module tb_fetch_timing_generator;

    logic phi_2 = 1'b1;
    logic res_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   check_en = 1'b0;

    int m_t   = 2;
    int m_ir  = 0;
    bit m_rst = 1'b1;
    bit m_irq = 1'b0;

    fetch_timing_generator_if bus ();

    fetch_timing_generator dut (
        .phi_2 (phi_2),
        .res_n (res_n),
        .bus   (bus)
    );

    always #5 phi_2 = ~phi_2;

    // Reference model: instruction cycle counter plus the opcode and sequence flags.
    always @(negedge phi_2 or negedge res_n) begin
        if (!res_n) begin
            m_t   <= 2;
            m_ir  <= 0;
            m_rst <= 1'b1;
            m_irq <= 1'b0;
        end else if (bus.rdy) begin
            if (m_t == 1)
                m_ir <= m_irq ? 0 : int'(bus.db_in);
            if (bus.t_end && m_t != 1) begin
                m_t   <= 1;
                m_irq <= bus.irq_pending;
                m_rst <= 1'b0;
            end else begin
                m_t <= (m_t < 7) ? m_t + 1 : 7;
            end
        end
    end

    function automatic int modelIpc();
        int low;
        low = m_ir % 16;
        if (!bus.rdy || m_irq) return 0;
        if (m_t == 1) return 1;
        if (m_rst) return 0;
        if (m_t == 2) return (low == 8 || low == 10) ? 0 : 1;
        return bus.pc_inc_req ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, well before the falling edge, compare all outputs with the model.
    always @(posedge phi_2) begin
        if (check_en) begin
            #3;
            checkOutput("cmp_t_state", int'(bus.t_state), m_t);
            checkOutput("cmp_sync",    int'(bus.sync),    (m_t == 1) ? 1 : 0);
            checkOutput("cmp_ir",      int'(bus.ir),      m_ir);
            checkOutput("cmp_rst_seq", int'(bus.rst_seq), int'(m_rst));
            checkOutput("cmp_irq_seq", int'(bus.irq_seq), int'(m_irq));
            checkOutput("cmp_i_pc",    int'(bus.i_pc),    modelIpc());
        end
    end

    task automatic applyStimulus(input bit rn, input bit r, input logic [7:0] d,
                                 input bit te, input bit pir, input bit ip);
        @(posedge phi_2);
        #1;
        res_n           = rn;
        bus.rdy         = r;
        bus.db_in       = d;
        bus.t_end       = te;
        bus.pc_inc_req  = pir;
        bus.irq_pending = ip;
        #2;
    endtask

    initial begin
        bus.rdy         = 1'b1;
        bus.db_in       = 8'h00;
        bus.t_end       = 1'b0;
        bus.pc_inc_req  = 1'b0;
        bus.irq_pending = 1'b0;
        #1;
        check_en = 1'b1;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hFF, 1, 1, 0);
        checkOutput("lit_reset_t_state", int'(bus.t_state), 2);
        checkOutput("lit_reset_ir", int'(bus.ir), 8'h00);
        checkOutput("lit_reset_rst_seq", int'(bus.rst_seq), 1);
        checkOutput("lit_reset_i_pc", int'(bus.i_pc), 0);

        // Reset BRK runs T2..T7, t_end at T7
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 8'h00, 0, 1, 0);
        applyStimulus(1, 1, 8'h00, 1, 1, 0);
        checkOutput("lit_rstseq_t7", int'(bus.t_state), 7);
        checkOutput("lit_rstseq_i_pc", int'(bus.i_pc), 0);

        // Two-byte fetch of A9
        applyStimulus(1, 1, 8'hA9, 0, 0, 0);
        checkOutput("lit_first_sync", int'(bus.sync), 1);
        checkOutput("lit_first_rst_clear", int'(bus.rst_seq), 0);
        checkOutput("lit_a9_t1_i_pc", int'(bus.i_pc), 1);
        applyStimulus(1, 1, 8'h00, 1, 0, 0);
        checkOutput("lit_a9_ir", int'(bus.ir), 8'hA9);
        checkOutput("lit_a9_t2_i_pc", int'(bus.i_pc), 1);
        checkOutput("lit_a9_t2_sync", int'(bus.sync), 0);

        // Single-byte predecode for E8 and 0A
        applyStimulus(1, 1, 8'hE8, 0, 0, 0);
        checkOutput("lit_e8_t1_i_pc", int'(bus.i_pc), 1);
        applyStimulus(1, 1, 8'h00, 1, 0, 0);
        checkOutput("lit_e8_t2_i_pc", int'(bus.i_pc), 0);
        applyStimulus(1, 1, 8'h0A, 0, 0, 0);
        checkOutput("lit_0a_t1_i_pc", int'(bus.i_pc), 1);
        applyStimulus(1, 1, 8'h00, 1, 0, 0);
        checkOutput("lit_0a_t2_i_pc", int'(bus.i_pc), 0);

        // Interrupt injection: irq sampled with t_end, fetched 4C discarded
        applyStimulus(1, 1, 8'hEA, 0, 0, 0);
        applyStimulus(1, 1, 8'h00, 1, 0, 1);
        applyStimulus(1, 1, 8'h4C, 0, 1, 0);
        checkOutput("lit_irq_seq_set", int'(bus.irq_seq), 1);
        checkOutput("lit_irq_t1_i_pc", int'(bus.i_pc), 0);
        applyStimulus(1, 1, 8'h00, 0, 1, 0);
        checkOutput("lit_irq_ir_zero", int'(bus.ir), 8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 8'h00, 0, 1, 0);
        applyStimulus(1, 1, 8'h00, 1, 1, 0);
        checkOutput("lit_irq_t7", int'(bus.t_state), 7);
        checkOutput("lit_irq_t7_i_pc", int'(bus.i_pc), 0);

        // Stall during T1 while the bus changes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, (i < 2) ? 8'h11 : 8'h22, 0, 1, 0);
            checkOutput("lit_stall_t_state", int'(bus.t_state), 1);
            checkOutput("lit_stall_sync", int'(bus.sync), 1);
            checkOutput("lit_stall_i_pc", int'(bus.i_pc), 0);
        end
        checkOutput("lit_irq_cleared", int'(bus.irq_seq), 0);
        applyStimulus(1, 1, 8'h33, 0, 0, 0);
        checkOutput("lit_unstall_i_pc", int'(bus.i_pc), 1);

        // Ten cycles without t_end: counter saturates at T7
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 8'h00, 0, i[0], 0);
            if (i == 0) checkOutput("lit_ir_33", int'(bus.ir), 8'h33);
        end
        checkOutput("lit_sat_t7", int'(bus.t_state), 7);
        applyStimulus(1, 1, 8'h00, 1, 0, 0);
        applyStimulus(1, 1, 8'hA9, 1, 0, 0);
        applyStimulus(1, 1, 8'h00, 0, 0, 0);
        checkOutput("lit_stray_t_end", int'(bus.t_state), 2);
        checkOutput("lit_stray_sync", int'(bus.sync), 0);

        // Reset asserted mid-instruction takes effect immediately
        applyStimulus(0, 1, 8'h55, 0, 1, 0);
        checkOutput("lit_midreset_t_state", int'(bus.t_state), 2);
        checkOutput("lit_midreset_ir", int'(bus.ir), 8'h00);
        checkOutput("lit_midreset_rst_seq", int'(bus.rst_seq), 1);

        // Interrupt sampled at the end of the reset sequence starts afterwards
        applyStimulus(1, 1, 8'h00, 1, 0, 1);
        applyStimulus(1, 1, 8'h4C, 0, 0, 0);
        checkOutput("lit_prio_irq_seq", int'(bus.irq_seq), 1);
        checkOutput("lit_prio_rst_seq", int'(bus.rst_seq), 0);
        checkOutput("lit_prio_i_pc", int'(bus.i_pc), 0);
        applyStimulus(1, 1, 8'h00, 0, 0, 0);
        checkOutput("lit_prio_ir", int'(bus.ir), 8'h00);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_timing_generator.md
# fetch_timing_generator

Cycle timing and opcode-fetch sequencer that sits directly upstream of the program counter. It tracks the T-state within each instruction, latches the opcode from the data bus into the instruction register, and predecodes instruction length. From these it generates the `i_pc` increment request consumed by the PC low incrementer. It also injects the forced-BRK sequences for reset and interrupts.

## Interface
- No parameters.
- `phi_2`  in  1  clock; all state updates on negedge `phi_2`, the same edge the PC registers use.
- `res_n`  in  1  reset, asynchronous, active-low.
- `rdy`  in  1  ready; low stalls the sequencer.
- `db_in`  in  8  memory data bus (opcode during fetch).
- `t_end`  in  1  from decode: the current cycle is the last of the instruction.
- `pc_inc_req`  in  1  from decode: request a PC increment in T3 and later.
- `irq_pending`  in  1  masked interrupt request, sampled only with `t_end`.
- `sync`  out  1  high during the opcode-fetch cycle (T1).
- `t_state`  out  3  cycle index: 1 = opcode fetch, 2..7 = execute.
- `ir`  out  8  instruction register.
- `i_pc`  out  1  PC increment enable (combinational), to the PC low incrementer.
- `rst_seq`  out  1  high while the reset BRK sequence runs.
- `irq_seq`  out  1  high while the interrupt BRK sequence runs.

## Operation
- **Reset.** While `res_n` is low: `t_state`=2, `sync`=0, `ir`=8'h00, `rst_seq`=1, `irq_seq`=0, `i_pc`=0.
  - After release, the sequencer executes the injected BRK from T2 with `rst_seq` held.
- **Stall.** When `rdy` is low, every register holds, `i_pc`=0, and `t_end` is ignored.
- **Advance.** On each negedge with `rdy`=1:
  - If `t_end`=1 and `t_state`≠1: next `t_state`=1, `sync`=1, `irq_seq`<=`irq_pending`, `rst_seq`<=0.
  - Otherwise `t_state` increments, saturating at 7, and `sync`<=0.
  - `t_end` asserted in T1 is ignored.
- **IR load.** At the negedge ending T1 (`sync`=1, `rdy`=1):
  - `ir`<=`db_in` when `irq_seq`=0.
  - `ir`<=8'h00 when `irq_seq`=1, so the fetched byte is discarded.
- **Predecode.** `single_byte` = (`ir`[3:0]==4'h8) or (`ir`[3:0]==4'hA). It is evaluated on the `ir` value held during T2.
- **`i_pc` rules** (all gated by `rdy`):
  - T1: 1, unless `irq_seq` is set.
  - T2: 1, unless `single_byte`, `irq_seq` or `rst_seq` is set.
  - T3..T7: equals `pc_inc_req`, unless `irq_seq` or `rst_seq` is set.
- **`irq_seq`** stays high from the T1 that follows its sampling until the next `t_end`.
- **Sequence priority.** `rst_seq` has priority over `irq_seq`: `irq_pending` sampled while `rst_seq`=1 still sets `irq_seq`, and the resulting sequence starts only after the reset sequence ends.

## Timing
- `sync`, `t_state`, `ir`, `rst_seq` and `irq_seq` are registered and change only on negedge `phi_2` or on async reset.
- `i_pc` is combinational from registered state plus `rdy` and `pc_inc_req`. It is valid before the same negedge that the PC register samples.
- Opcode fetch to first execute cycle: 1 cycle. The shortest instruction is 2 cycles (T1, then T2 with `t_end`).
- Reset asserted mid-instruction or mid-stall overrides everything immediately; no partial IR load occurs.
- `rdy` falling during T1: `sync` stays high and `ir` is not loaded until `rdy` returns.

## Test plan
- **Reset release.** Hold `res_n`=0 for 3 cycles, release, assert `t_end` at `t_state`=7.
  - Required: `ir`=00, `rst_seq`=1, `i_pc`=0 throughout; next cycle `sync`=1, `t_state`=1, `rst_seq`=0.
- **Two-byte fetch.** `db_in`=8'hA9 in T1, then `t_end` in T2.
  - Required: `ir`=A9; `i_pc`=1 in both T1 and T2; `sync` high exactly on alternate cycles.
- **Single-byte predecode.** `db_in`=8'hE8 (INX) in T1, then `t_end` in T2.
  - Required: `i_pc`=1 in T1, 0 in T2. Repeat with 8'h0A: same result.
- **Interrupt injection.** `irq_pending`=1 with `t_end`, then `db_in`=8'h4C in the next T1.
  - Required: `irq_seq`=1, `ir`=00 (not 4C), `i_pc`=0 in T1..T7; `irq_seq` clears at the following T1.
- **Stall.** Drop `rdy` for 4 cycles during T1 while `db_in` changes 11→22, then raise `rdy` with `db_in`=8'h33.
  - Required: `t_state`=1, `sync`=1 and `i_pc`=0 held throughout the stall; `ir`=33 afterwards.
- **Saturation and stray `t_end`.** Never assert `t_end` for 10 cycles, then assert `t_end` during T1.
  - Required: `t_state` holds at 7; `t_end` in T1 has no effect and `t_state` goes to 2.
